atm_keypad_frontend: RTL and testbench
======================================

ATM_KEYPAD_FRONTEND -- requirements
Module: atm_keypad_frontend

Interface
REQ-001 clk  in  1  system clock; all logic on rising edge.
REQ-002 rst  in  1  reset, asynchronous, active-high.
REQ-003 card_detect  in  1  card-slot sensor level, 1 = card present (pre-synchronised).
REQ-004 key_valid  in  1  one-cycle strobe, key_cmd/key_code valid.
REQ-005 key_cmd  in  1  1 = command key, 0 = data key.
REQ-006 key_code  in  4  data: nibble 0-15; command: 0 ENTER, 1 CANCEL, 2 CLEAR, 3 HOME, 4 WDRAW, 5 DEPOS, 6 BALNC, 7 LANG, 8-15 ignored.
REQ-007 pin_ok / pin_rej  in  1 each  controller verdict strobes for last submitted PIN.
REQ-008 insert_card, language_chosen, pin_valid, op_valid, exit, home_in  out  1 each  one-cycle pulses to controller.
REQ-009 pin  out  4  held PIN nibble; operation  out  2  held opcode (00 withdraw, 01 deposit, 10 balance, 11 exit).
REQ-010 withdraw_amount, deposit_amount  out  6 each  held amount levels, 0 when not confirmed.
REQ-011 fe_state  out  3  current state code, for debug.

Function
REQ-012 States SHALL be IDLE, LANG, PIN, PWAIT, MENU, AMOUNT, HOLD; all outputs registered.
REQ-013 IDLE: card_detect 0->1 edge SHALL pulse insert_card next cycle and enter LANG; level already high at reset exit SHALL not trigger.
REQ-014 LANG: cmd LANG SHALL pulse language_chosen and enter PIN; other keys ignored.
REQ-015 PIN: data key SHALL load pin register (last key wins); CLEAR SHALL zero it; ENTER SHALL pulse pin_valid and enter PWAIT.
REQ-016 PWAIT: pin_ok -> MENU; pin_rej or 16 cycles without verdict -> tries+1, back to PIN; third failure SHALL pulse exit and go IDLE; keys ignored in PWAIT; pin_ok and pin_rej same cycle SHALL count as reject.
REQ-017 MENU: WDRAW/DEPOS SHALL set operation 00/01, pulse op_valid, enter AMOUNT; BALNC SHALL set 10, pulse op_valid, stay MENU; other keys ignored.
REQ-018 AMOUNT: data key d<=9 SHALL update acc = acc*10+d, saturating at 63; d>9 ignored; max 2 accepted digits, further digits ignored; CLEAR SHALL zero acc and digit count.
REQ-019 AMOUNT ENTER with acc>0 SHALL drive acc onto withdraw_amount (op 00) or deposit_amount (op 01) and enter HOLD; ENTER with acc=0 ignored.
REQ-020 HOLD: amount held exactly 2 cycles, then both amounts zeroed and return to MENU with acc cleared.
REQ-021 HOME in AMOUNT SHALL pulse home_in, zero acc, return to MENU.
REQ-022 CANCEL in any state except IDLE SHALL pulse exit, set operation 11 for that cycle, clear pin/acc/tries, go IDLE.
REQ-023 card_detect low in any state except IDLE SHALL act as CANCEL and take priority over a same-cycle key.
REQ-024 At most one output pulse per cycle; pulses never exceed one cycle.

Reset
REQ-025 rst SHALL force IDLE; all pulses 0; pin, operation, amounts, acc, tries, timeout counter 0; card edge detector history = 1 (REQ-013).
REQ-026 rst mid-session SHALL abandon session without an exit pulse.

Structure
REQ-027 Shared package atm_pkg SHALL hold state enum, command key codes, opcode constants, AMT_W=6, AMT_MAX=63, PIN_TRIES=3, VERDICT_TIMEOUT=16.
REQ-028 Decimal accumulator (mult-by-10, saturate, digit count, clear) SHALL be sub-module atm_amount_accum.

Verification
REQ-029 card 0->1, LANG, data 15, ENTER, pin_ok -> insert_card, language_chosen, pin_valid with pin=15 each one pulse, fe_state=MENU.
REQ-030 MENU WDRAW, keys 2,5, ENTER -> op_valid with operation=00, withdraw_amount=25 for 2 cycles then 0, back to MENU.
REQ-031 DEPOS, keys 9,9,9, ENTER -> deposit_amount=63 (saturation, third digit ignored).
REQ-032 three PIN submissions answered pin_rej, pin_rej, no verdict for 16 cycles -> exit pulse on third failure, IDLE.
REQ-033 AMOUNT with acc=7, card_detect drops same cycle as ENTER -> exit pulse, amounts stay 0, IDLE.
REQ-034 rst asserted in PWAIT -> all outputs 0 immediately, no exit pulse, IDLE; card still present -> no insert_card until card re-edge.

Source files
------------

// File: rtl/atm_pkg.sv
// atm_pkg: shared states, key codes, opcodes and limits for the ATM keypad front end
package atm_pkg;
   localparam int AMT_W = 6;
   localparam int AMT_MAX = 63;
   localparam int PIN_TRIES = 3;
   localparam int VERDICT_TIMEOUT = 16;
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LANG,
      ST_PIN,
      ST_PWAIT,
      ST_MENU,
      ST_AMOUNT,
      ST_HOLD
   } fe_state_t;
   localparam int CMD_ENTER = 0;
   localparam int CMD_CANCEL = 1;
   localparam int CMD_CLEAR = 2;
   localparam int CMD_HOME = 3;
   localparam int CMD_WDRAW = 4;
   localparam int CMD_DEPOS = 5;
   localparam int CMD_BALNC = 6;
   localparam int CMD_LANG = 7;
   localparam logic [1:0] OP_WDRAW = 2'b00;
   localparam logic [1:0] OP_DEPOS = 2'b01;
   localparam logic [1:0] OP_BALNC = 2'b10;
   localparam logic [1:0] OP_EXIT = 2'b11;
   // one-hot pulse codes, order {insert_card, language_chosen, pin_valid, op_valid, exit, home_in}
   localparam logic [5:0] PL_INSERT = 6'b100000;
   localparam logic [5:0] PL_LANG = 6'b010000;
   localparam logic [5:0] PL_PIN = 6'b001000;
   localparam logic [5:0] PL_OP = 6'b000100;
   localparam logic [5:0] PL_EXIT = 6'b000010;
   localparam logic [5:0] PL_HOME = 6'b000001;
endpackage

// File: rtl/atm_amount_accum.sv
// atm_amount_accum: two-digit decimal amount accumulator saturating at AMT_MAX
module atm_amount_accum
   import atm_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             add,
   input  logic [3:0]       digit,
   output logic [AMT_W-1:0] acc
);
   logic [1:0] ndig;
   logic [9:0] sum;
   assign sum = 10'(acc) * 10'd10 + 10'(digit);
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         acc <= '0;
         ndig <= '0;
      end else if (clr) begin
         acc <= '0;
         ndig <= '0;
      end else if (add && digit <= 4'd9 && ndig < 2'd2) begin
         acc <= sum > 10'(AMT_MAX) ? AMT_W'(AMT_MAX) : sum[AMT_W-1:0];
         ndig <= ndig + 2'd1;
      end
endmodule

// File: rtl/atm_keypad_frontend.sv
// atm_keypad_frontend: card/keypad sequencer for language, PIN, menu and amount entry
module atm_keypad_frontend
   import atm_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             card_detect,
   input  logic             key_valid,
   input  logic             key_cmd,
   input  logic [3:0]       key_code,
   input  logic             pin_ok,
   input  logic             pin_rej,
   output logic             insert_card,
   output logic             language_chosen,
   output logic             pin_valid,
   output logic             op_valid,
   output logic             exit,
   output logic             home_in,
   output logic [3:0]       pin,
   output logic [1:0]       operation,
   output logic [AMT_W-1:0] withdraw_amount,
   output logic [AMT_W-1:0] deposit_amount,
   output logic [2:0]       fe_state
);
   fe_state_t state, state_n;
   logic card_prev, acc_clr, acc_add, data, cancel;
   logic [1:0] tries, tries_n, op_n;
   logic [3:0] cnt, cnt_n, pin_n;
   logic [5:0] pulse, pulse_n;
   logic [7:0] k;
   logic [AMT_W-1:0] acc, wamt_n, damt_n;
   assign k = (key_valid && key_cmd && !key_code[3]) ? 8'd1 << key_code[2:0] : 8'd0;
   assign data = key_valid & ~key_cmd;
   // card removal behaves like CANCEL and outranks any key in the same cycle
   assign cancel = state != ST_IDLE && (!card_detect || k[CMD_CANCEL]);
   assign {insert_card, language_chosen, pin_valid, op_valid, exit, home_in} = pulse;
   assign fe_state = state;
   atm_amount_accum u_acc (
      .clk(clk),
      .rst(rst),
      .clr(acc_clr),
      .add(acc_add),
      .digit(key_code),
      .acc(acc)
   );
   always_comb begin
      state_n = state;
      tries_n = tries;
      cnt_n = cnt;
      pin_n = pin;
      op_n = operation;
      wamt_n = withdraw_amount;
      damt_n = deposit_amount;
      pulse_n = '0;
      acc_clr = 1'b0;
      acc_add = 1'b0;
      if (cancel) begin
         state_n = ST_IDLE;
         tries_n = '0;
         cnt_n = '0;
         pin_n = '0;
         op_n = OP_EXIT;
         wamt_n = '0;
         damt_n = '0;
         pulse_n = PL_EXIT;
         acc_clr = 1'b1;
      end else begin
         case (state)
            ST_IDLE: begin
               op_n = OP_WDRAW;
               if (card_detect && !card_prev) begin
                  state_n = ST_LANG;
                  pulse_n = PL_INSERT;
               end
            end
            ST_LANG:
               if (k[CMD_LANG]) begin
                  state_n = ST_PIN;
                  pulse_n = PL_LANG;
               end
            ST_PIN:
               if (data) pin_n = key_code;
               else if (k[CMD_CLEAR]) pin_n = '0;
               else if (k[CMD_ENTER]) begin
                  state_n = ST_PWAIT;
                  pulse_n = PL_PIN;
                  cnt_n = '0;
               end
            ST_PWAIT:
               if (pin_ok && !pin_rej) begin
                  state_n = ST_MENU;
                  tries_n = '0;
               end else if (pin_rej || cnt == 4'(VERDICT_TIMEOUT - 1)) begin
                  cnt_n = '0;
                  if (tries == 2'(PIN_TRIES - 1)) begin
                     state_n = ST_IDLE;
                     tries_n = '0;
                     pin_n = '0;
                     pulse_n = PL_EXIT;
                  end else begin
                     state_n = ST_PIN;
                     tries_n = tries + 2'd1;
                  end
               end else cnt_n = cnt + 4'd1;
            ST_MENU:
               if (k[CMD_WDRAW] || k[CMD_DEPOS]) begin
                  state_n = ST_AMOUNT;
                  op_n = k[CMD_DEPOS] ? OP_DEPOS : OP_WDRAW;
                  pulse_n = PL_OP;
                  acc_clr = 1'b1;
               end else if (k[CMD_BALNC]) begin
                  op_n = OP_BALNC;
                  pulse_n = PL_OP;
               end
            ST_AMOUNT:
               if (k[CMD_HOME]) begin
                  state_n = ST_MENU;
                  pulse_n = PL_HOME;
                  acc_clr = 1'b1;
               end else if (k[CMD_CLEAR]) acc_clr = 1'b1;
               else if (k[CMD_ENTER] && acc != '0) begin
                  state_n = ST_HOLD;
                  wamt_n = operation == OP_DEPOS ? '0 : acc;
                  damt_n = operation == OP_DEPOS ? acc : '0;
                  cnt_n = '0;
               end else acc_add = data;
            ST_HOLD:
               if (cnt == 4'd1) begin
                  state_n = ST_MENU;
                  wamt_n = '0;
                  damt_n = '0;
                  cnt_n = '0;
                  acc_clr = 1'b1;
               end else cnt_n = cnt + 4'd1;
            default: state_n = ST_IDLE;
         endcase
      end
   end
   // card history resets high so a card already present at reset exit is not an insertion
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= ST_IDLE;
         card_prev <= 1'b1;
         tries <= '0;
         cnt <= '0;
         pin <= '0;
         operation <= '0;
         withdraw_amount <= '0;
         deposit_amount <= '0;
         pulse <= '0;
      end else begin
         state <= state_n;
         card_prev <= card_detect;
         tries <= tries_n;
         cnt <= cnt_n;
         pin <= pin_n;
         operation <= op_n;
         withdraw_amount <= wamt_n;
         deposit_amount <= damt_n;
         pulse <= pulse_n;
      end
endmodule

// File: tb/tb_atm_keypad_frontend.sv
// tb_atm_keypad_frontend: directed session scenarios checked against a session-level model
module tb_atm_keypad_frontend;
   logic clk = 0, rst = 1, card_detect = 1, key_valid = 0, key_cmd = 0, pin_ok = 0, pin_rej = 0;
   logic [3:0] key_code = 0;
   logic insert_card, language_chosen, pin_valid, op_valid, exit, home_in;
   logic [3:0] pin;
   logic [1:0] operation;
   logic [5:0] withdraw_amount, deposit_amount;
   logic [2:0] fe_state;
   int checks = 0, errors = 0;
   bit active, have_lang, pin_sent, pin_good, in_amount, prev_cd;
   int wait_left, hold_left, fails, acc, digits;
   int e_ins, e_lang, e_pv, e_opv, e_exit, e_home, e_pin, e_op, e_w, e_d, e_state;

   atm_keypad_frontend dut (
      .clk(clk), .rst(rst), .card_detect(card_detect), .key_valid(key_valid),
      .key_cmd(key_cmd), .key_code(key_code), .pin_ok(pin_ok), .pin_rej(pin_rej),
      .insert_card(insert_card), .language_chosen(language_chosen), .pin_valid(pin_valid),
      .op_valid(op_valid), .exit(exit), .home_in(home_in), .pin(pin), .operation(operation),
      .withdraw_amount(withdraw_amount), .deposit_amount(deposit_amount), .fe_state(fe_state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp_v);
      checks++;
      if (act != exp_v) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp_v, $time);
      end
   endtask

   function automatic bit ck(input int c);
      return key_valid && key_cmd && key_code == c;
   endfunction

   // session model: phase flags and countdowns, outputs are what each edge must produce
   always @(posedge clk or posedge rst) begin
      e_ins = 0; e_lang = 0; e_pv = 0; e_opv = 0; e_exit = 0; e_home = 0;
      if (rst) begin
         active = 0; prev_cd = 1; e_pin = 0; e_op = 0; e_w = 0; e_d = 0;
         fails = 0; acc = 0; digits = 0; hold_left = 0; in_amount = 0;
      end else begin
         if (!active) begin
            e_op = 0;
            if (card_detect && !prev_cd) begin
               active = 1; have_lang = 0; pin_sent = 0; pin_good = 0; in_amount = 0; hold_left = 0;
               e_ins = 1;
            end
         end else if (!card_detect || ck(1)) begin
            e_exit = 1; e_op = 3; e_pin = 0; e_w = 0; e_d = 0;
            fails = 0; acc = 0; digits = 0; active = 0; hold_left = 0; in_amount = 0;
         end else if (!have_lang) begin
            if (ck(7)) begin have_lang = 1; e_lang = 1; end
         end else if (!pin_good && !pin_sent) begin
            if (key_valid && !key_cmd) e_pin = key_code;
            else if (ck(2)) e_pin = 0;
            else if (ck(0)) begin e_pv = 1; pin_sent = 1; wait_left = 16; end
         end else if (pin_sent) begin
            if (pin_ok && !pin_rej) begin pin_sent = 0; pin_good = 1; fails = 0; end
            else begin
               wait_left--;
               if (pin_rej || wait_left == 0) begin
                  pin_sent = 0;
                  fails++;
                  if (fails == 3) begin e_exit = 1; active = 0; fails = 0; e_pin = 0; end
               end
            end
         end else if (hold_left > 0) begin
            hold_left--;
            if (hold_left == 0) begin e_w = 0; e_d = 0; acc = 0; digits = 0; end
         end else if (in_amount) begin
            if (ck(3)) begin e_home = 1; acc = 0; digits = 0; in_amount = 0; end
            else if (ck(2)) begin acc = 0; digits = 0; end
            else if (ck(0) && acc > 0) begin
               if (e_op == 0) e_w = acc; else e_d = acc;
               hold_left = 2; in_amount = 0;
            end else if (key_valid && !key_cmd && key_code <= 9 && digits < 2) begin
               acc = acc * 10 + key_code;
               if (acc > 63) acc = 63;
               digits++;
            end
         end else begin
            if (ck(4) || ck(5)) begin e_op = ck(5); e_opv = 1; in_amount = 1; acc = 0; digits = 0; end
            else if (ck(6)) begin e_op = 2; e_opv = 1; end
         end
         prev_cd = card_detect;
      end
      e_state = !active ? 0 : !have_lang ? 1 : pin_sent ? 3 : !pin_good ? 2 :
                hold_left > 0 ? 6 : in_amount ? 5 : 4;
   end

   always @(negedge clk) begin
      chk("insert_card", insert_card, e_ins);
      chk("language_chosen", language_chosen, e_lang);
      chk("pin_valid", pin_valid, e_pv);
      chk("op_valid", op_valid, e_opv);
      chk("exit", exit, e_exit);
      chk("home_in", home_in, e_home);
      chk("pin", pin, e_pin);
      chk("operation", operation, e_op);
      chk("withdraw_amount", withdraw_amount, e_w);
      chk("deposit_amount", deposit_amount, e_d);
      chk("fe_state", fe_state, e_state);
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic key(input logic c, input logic [3:0] code);
      key_valid = 1; key_cmd = c; key_code = code;
      @(negedge clk);
      key_valid = 0;
   endtask

   task automatic verdict(input logic ok, input logic rj);
      pin_ok = ok; pin_rej = rj;
      @(negedge clk);
      pin_ok = 0; pin_rej = 0;
   endtask

   initial begin
      step(3);
      rst = 0;
      step(2);
      chk("card high at reset exit: state", fe_state, 0);
      chk("card high at reset exit: insert", insert_card, 0);
      card_detect = 0; step(2); card_detect = 1; step(1);
      chk("insert pulse", insert_card, 1);
      chk("state LANG", fe_state, 1);
      key(0, 3);
      chk("data ignored in LANG", fe_state, 1);
      key(1, 7);
      chk("language_chosen", language_chosen, 1);
      key(0, 4); key(0, 15); key(1, 0);
      chk("pin_valid", pin_valid, 1);
      chk("pin last key wins", pin, 15);
      chk("state PWAIT", fe_state, 3);
      step(3);
      verdict(1, 0);
      chk("state MENU after pin_ok", fe_state, 4);
      key(1, 4);
      chk("op_valid wdraw", op_valid, 1);
      chk("operation wdraw", operation, 0);
      key(0, 2); key(0, 5); key(1, 0);
      chk("withdraw 25 cycle 1", withdraw_amount, 25);
      chk("state HOLD", fe_state, 6);
      step(1);
      chk("withdraw 25 cycle 2", withdraw_amount, 25);
      step(1);
      chk("withdraw cleared", withdraw_amount, 0);
      chk("back to MENU", fe_state, 4);
      key(1, 6);
      chk("operation balance", operation, 2);
      chk("balance stays MENU", fe_state, 4);
      key(1, 5);
      chk("operation deposit", operation, 1);
      key(0, 9); key(0, 9); key(0, 9); key(1, 0);
      chk("deposit saturates 63", deposit_amount, 63);
      step(2);
      chk("deposit cleared", deposit_amount, 0);
      key(1, 5); key(1, 0);
      chk("ENTER with acc 0 ignored", fe_state, 5);
      key(0, 12); key(1, 2); key(0, 7); key(1, 3);
      chk("home_in", home_in, 1);
      chk("HOME to MENU", fe_state, 4);
      key(1, 4); key(0, 7);
      key_valid = 1; key_cmd = 1; key_code = 0; card_detect = 0;
      step(1);
      key_valid = 0;
      chk("card drop beats ENTER: exit", exit, 1);
      chk("card drop: operation exit", operation, 3);
      chk("card drop: withdraw 0", withdraw_amount, 0);
      chk("card drop: IDLE", fe_state, 0);
      step(1);
      chk("operation after exit", operation, 0);
      card_detect = 1; step(1);
      key(1, 7); key(0, 5); key(1, 0);
      verdict(0, 1);
      chk("first reject to PIN", fe_state, 2);
      key(1, 0);
      verdict(1, 1);
      chk("ok+rej counts as reject", fe_state, 2);
      key(1, 0);
      step(15);
      chk("still waiting at 15", fe_state, 3);
      step(1);
      chk("timeout third failure exit", exit, 1);
      chk("third failure IDLE", fe_state, 0);
      card_detect = 0; step(1); card_detect = 1; step(1);
      chk("re-insert", insert_card, 1);
      key(1, 1);
      chk("CANCEL exit", exit, 1);
      chk("CANCEL operation", operation, 3);
      card_detect = 0; step(1); card_detect = 1; step(1);
      key(1, 7); key(0, 9); key(1, 0);
      chk("PWAIT before reset", fe_state, 3);
      step(2);
      #2 rst = 1;
      #1;
      chk("async reset state", fe_state, 0);
      chk("async reset pin", pin, 0);
      chk("async reset no exit", exit, 0);
      @(negedge clk);
      rst = 0;
      step(4);
      chk("no insert without re-edge", insert_card, 0);
      chk("idle after reset", fe_state, 0);
      card_detect = 0; step(1); card_detect = 1; step(1);
      chk("insert after re-edge", insert_card, 1);
      step(2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
